// File: rtl/dmem_responder.sv
// Single-port data-memory responder with valid/ready request and response channels.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being aligned down.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          req_ready_q, rsp_valid_q, err_q;
  logic [31:0]   rdata_q;
  logic          we_q, uns_q;
  logic [1:0]    size_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          idle, enter_resp, misalign, mem_we;
  logic          cur_we, cur_uns;
  logic [1:0]    cur_size;
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic [AW-1:0] idx;
  logic [31:0]   word, ld_ext, rdata_d, wdata_rep;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [3:0]    be;
  logic          err_d;
  logic          unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];

  // The acceptance edge may also be the RESP-entry edge (WAIT_CYCLES=0), so use live fields in IDLE.
  assign idle      = (state_q == IDLE);
  assign cur_we    = idle ? req_we               : we_q;
  assign cur_uns   = idle ? req_unsigned         : uns_q;
  assign cur_size  = idle ? req_size             : size_q;
  assign cur_addr  = idle ? req_addr[AW+1:0]     : addr_q;
  assign cur_wdata = idle ? req_wdata            : wdata_q;

  assign enter_resp = (idle && req_valid && (WAIT_CYCLES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd1));
  assign idx  = cur_addr[AW+1:2];
  assign word = mem[idx];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((cur_size == 2'b01) && cur_addr[0]) ||
                    (cur_size[1] && (cur_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    lane_b    = 8'h00;
    lane_h    = cur_addr[1] ? word[31:16] : word[15:0];
    ld_ext    = word;
    be        = 4'b1111;
    wdata_rep = cur_wdata;
    case (cur_addr[1:0])
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    case (cur_size)
      2'b00: begin
        ld_ext    = cur_uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
        be        = 4'b0001 << cur_addr[1:0];
        wdata_rep = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        ld_ext    = cur_uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
        be        = cur_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{cur_wdata[15:0]}};
      end
      default: ;
    endcase
    rdata_d = (cur_we || misalign) ? 32'h0 : ld_ext;
    err_d   = misalign;
  end

  assign mem_we = reset && enter_resp && cur_we && !misalign;

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            uns_q       <= req_unsigned;
            size_q      <= req_size;
            addr_q      <= req_addr[AW+1:0];
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rdata_q     <= rdata_d;
              err_q       <= err_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q     <= RESP;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b1;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WAIT_CYCLES=1, DEPTH_WORDS=256); honours DMEM_MISALIGN_TRAP_EN.
module tb_dmem_responder;
  localparam int W = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int errors = 0;
  int checks = 0;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Latency counts the acceptance cycle as 0; lat is the cycle index where rsp_valid is first seen.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata; er = rsp_err;
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", rsp_err); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, rd, er, lat);
    checks++; if (lat != 1 + W) begin errors++; $display("FAIL store_latency got %0d want %0d", lat, 1 + W); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL store_rdata got %h want 0", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL store_err got %b want 0", er); end
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checks++; if (lat != 1 + W) begin errors++; $display("FAIL load_latency got %0d want %0d", lat, 1 + W); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_word got %h want deadbeef", rd); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL retire_idle got %b want 1", req_ready); end
  endtask

  task automatic test_load_ext;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_13 got %h want ffffffde", rd); end
    do_req(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL lbu_13 got %h want 000000de", rd); end
    do_req(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh_12 got %h want ffffdead", rd); end
    do_req(1'b0, 32'h10, 2'b01, 1'b1, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_10 got %h want 0000beef", rd); end
    do_req(1'b0, 32'h11, 2'b00, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFFBE) begin errors++; $display("FAIL lb_11 got %h want ffffffbe", rd); end
    do_req(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL size11_word got %h want deadbeef", rd); end
  endtask

  task automatic test_store_byte;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h11, 2'b00, 1'b0, 32'hFFFFFF5A, rd, er, lat);
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD5AEF) begin errors++; $display("FAIL sb_11 got %h want dead5aef", rd); end
  endtask

  task automatic test_hold;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clk); #1;
    // Keep a conflicting request asserted; it must be ignored outside IDLE.
    req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'h12345678;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b want 1", i, rsp_valid); end
      checks++; if (rsp_rdata !== 32'hDEAD5AEF) begin errors++; $display("FAIL hold_rdata[%0d] got %h want dead5aef", i, rsp_rdata); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %b want 0", i, req_ready); end
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL release_valid got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", req_ready); end
    @(negedge clk); req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic test_misalign;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h12, 2'b10, 1'b0, 32'h11223344, rd, er, lat);
    checks++; if (lat != 1 + W) begin errors++; $display("FAIL misalign_latency got %0d want %0d", lat, 1 + W); end
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_err got %b want 1", er); end
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD5AEF) begin errors++; $display("FAIL misalign_nowrite got %h want dead5aef", rd); end
    do_req(1'b0, 32'h11, 2'b01, 1'b0, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misalign_lh got err=%b rd=%h want err=1 rd=0", er, rd); end
`else
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL misalign_err got %b want 0", er); end
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL misalign_write got %h want 11223344", rd); end
    do_req(1'b0, 32'h13, 2'b01, 1'b1, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00001122) begin errors++; $display("FAIL lhu_13 got %h want 00001122", rd); end
`endif
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h20, 2'b10, 1'b0, 32'h01234567, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 2'b10; req_wdata = 32'hAAAAAAAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL midreset_async got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", rsp_valid); end
    @(negedge clk); reset = 1'b1;
    do_req(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h01234567) begin errors++; $display("FAIL midreset_nowrite got %h want 01234567", rd); end
    do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++; if (rd !== 32'hDEAD5AEF) begin errors++; $display("FAIL reset_keeps_mem got %h want dead5aef", rd); end
`else
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL reset_keeps_mem got %h want 11223344", rd); end
`endif
  endtask

  task automatic test_wrap;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h0, 2'b10, 1'b0, 32'h89ABCDEF, rd, er, lat);
    do_req(1'b0, 32'h400, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h89ABCDEF || er !== 1'b0) begin errors++; $display("FAIL wrap_400 got rd=%h err=%b want 89abcdef/0", rd, er); end
    do_req(1'b1, 32'h7FC, 2'b10, 1'b0, 32'h13572468, rd, er, lat);
    do_req(1'b0, 32'h3FC, 2'b10, 1'b0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h13572468) begin errors++; $display("FAIL wrap_3fc got %h want 13572468", rd); end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b0; reset = 1'b0;
    test_reset();
    test_store_load();
    test_load_ext();
    test_store_byte();
    test_hold();
    test_misalign();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
